dtm_dmi_hs: RTL and testbench

- Parametrised JTAG Debug Transport Module (RISC-V debug spec 0.13 style), successor to the single-cycle DTM.
- Synchronises the raw JTAG pins into `clk`, runs the 16-state TAP controller and exposes IDCODE, DTMCS, DMI and BYPASS data registers.
- Drives the Debug Module through a req/ack handshake that tolerates multi-cycle DM latency.
- Reports busy/error status in the DMI scan, with dmireset and dmihardreset recovery.

---
 rtl/dtm_dmi_hs_if.sv | 22 ++
 rtl/dtm_dmi_hs.sv | 187 ++++++++++++++++++
 tb/tb_dtm_dmi_hs.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dtm_dmi_hs_if.sv
// DMI request/acknowledge bundle between the debug transport module and the Debug Module.
interface dtm_dmi_hs_if #(
    parameter int unsigned ABITS = 7
);
    logic             req;
    logic             write;
    logic [ABITS-1:0] addr;
    logic [31:0]      wdata;
    logic             ack;
    logic [31:0]      rdata;
    logic             err;

    modport master (
        output req, write, addr, wdata,
        input  ack, rdata, err
    );

    modport slave (
        input  req, write, addr, wdata,
        output ack, rdata, err
    );
endinterface

// File: rtl/dtm_dmi_hs.sv
// JTAG debug transport: pin synchroniser, TAP, IDCODE/DTMCS/DMI/BYPASS registers and a req/ack DMI port.
// Build option DTM_IDCODE_EN keeps the IDCODE instruction; without it the IR resets to BYPASS.
module dtm_dmi_hs #(
    parameter int unsigned ABITS      = 7,
    parameter logic [31:0] IDCODE_VAL = 32'h0000_0001,
    parameter logic [2:0]  IDLE_HINT  = 3'd1,
    parameter int unsigned IR_LEN     = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tck_ns,
    input  logic            tms_ns,
    input  logic            tdi_ns,
    output logic            tdo,
    dtm_dmi_hs_if.master    dmi
);
    localparam int unsigned DR_W = ABITS + 34;
`ifdef DTM_IDCODE_EN
    localparam logic [IR_LEN-1:0] IR_RST = IR_LEN'(5'h01);
`else
    localparam logic [IR_LEN-1:0] IR_RST = IR_LEN'(5'h1F);
`endif

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_t;

    typedef enum logic [1:0] {SEL_BYP, SEL_IDC, SEL_DTMCS, SEL_DMI} sel_t;

    logic [2:0]        tck_s, tms_s, tdi_s;
    tap_t              tap, tap_nxt_c;
    sel_t              sel_c;
    logic [IR_LEN-1:0] ir, ir_sr;
    logic [DR_W-1:0]   sr;
    logic [1:0]        sticky;
    logic [ABITS-1:0]  dr_addr;
    logic [31:0]       dr_data;
    logic              launch, discard;

    logic              rise_c, fall_c, tms, tdi;
    logic              ack_c, busy_c;
    logic [1:0]        sticky_a_c, cap_op_c, upd_op_c;
    logic [31:0]       dtmcs_c;
    logic              unused_c;

    assign rise_c   = !tck_s[2] && tck_s[1];
    assign fall_c   = tck_s[2] && !tck_s[1];
    assign tms      = tms_s[1];
    assign tdi      = tdi_s[1];
    assign unused_c = ^{tms_s[2], tdi_s[2]};

    // IEEE 1149.1 TAP next-state graph
    always_comb begin
        tap_nxt_c = tap;
        case (tap)
            TLR:    tap_nxt_c = tms ? TLR    : RTI;
            RTI:    tap_nxt_c = tms ? SEL_DR : RTI;
            SEL_DR: tap_nxt_c = tms ? SEL_IR : CAP_DR;
            CAP_DR: tap_nxt_c = tms ? EX1_DR : SH_DR;
            SH_DR:  tap_nxt_c = tms ? EX1_DR : SH_DR;
            EX1_DR: tap_nxt_c = tms ? UPD_DR : PAU_DR;
            PAU_DR: tap_nxt_c = tms ? EX2_DR : PAU_DR;
            EX2_DR: tap_nxt_c = tms ? UPD_DR : SH_DR;
            UPD_DR: tap_nxt_c = tms ? SEL_DR : RTI;
            SEL_IR: tap_nxt_c = tms ? TLR    : CAP_IR;
            CAP_IR: tap_nxt_c = tms ? EX1_IR : SH_IR;
            SH_IR:  tap_nxt_c = tms ? EX1_IR : SH_IR;
            EX1_IR: tap_nxt_c = tms ? UPD_IR : PAU_IR;
            PAU_IR: tap_nxt_c = tms ? EX2_IR : PAU_IR;
            EX2_IR: tap_nxt_c = tms ? UPD_IR : SH_IR;
            UPD_IR: tap_nxt_c = tms ? SEL_DR : RTI;
            default: tap_nxt_c = TLR;
        endcase
    end

    always_comb begin
        sel_c = SEL_BYP;
        if (ir == IR_LEN'(5'h10))      sel_c = SEL_DTMCS;
        else if (ir == IR_LEN'(5'h11)) sel_c = SEL_DMI;
`ifdef DTM_IDCODE_EN
        else if (ir == IR_LEN'(5'h01)) sel_c = SEL_IDC;
`endif
    end

    // A completing ack is folded in before any capture/update seen in the same clk
    always_comb begin
        ack_c      = dmi.ack && dmi.req;
        sticky_a_c = (ack_c && !discard && dmi.err) ? 2'd2 : sticky;
        busy_c     = launch || (dmi.req && !ack_c);
        cap_op_c   = busy_c ? 2'd3 : sticky_a_c;
        upd_op_c   = sr[1:0];
        dtmcs_c    = {17'd0, IDLE_HINT, sticky, 6'(ABITS), 4'd1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tck_s     <= '0;
            tms_s     <= '0;
            tdi_s     <= '0;
            tap       <= TLR;
            ir        <= IR_RST;
            ir_sr     <= '0;
            sr        <= '0;
            sticky    <= '0;
            dr_addr   <= '0;
            dr_data   <= '0;
            launch    <= 1'b0;
            discard   <= 1'b0;
            tdo       <= 1'b0;
            dmi.req   <= 1'b0;
            dmi.write <= 1'b0;
            dmi.addr  <= '0;
            dmi.wdata <= '0;
        end else begin
            tck_s  <= {tck_s[1:0], tck_ns};
            tms_s  <= {tms_s[1:0], tms_ns};
            tdi_s  <= {tdi_s[1:0], tdi_ns};
            sticky <= sticky_a_c;

            if (launch) begin
                dmi.req <= 1'b1;
                launch  <= 1'b0;
            end
            if (ack_c) begin
                dmi.req <= 1'b0;
                discard <= 1'b0;
                if (!discard && !dmi.write) dr_data <= dmi.rdata;
            end

            if (rise_c) begin
                tap <= tap_nxt_c;
                if (tap_nxt_c == TLR) ir <= IR_RST;
                case (tap)
                    CAP_IR: ir_sr <= IR_LEN'(5'h01);
                    SH_IR:  ir_sr <= {tdi, ir_sr[IR_LEN-1:1]};
                    CAP_DR: begin
                        case (sel_c)
                            SEL_IDC:   sr <= DR_W'(IDCODE_VAL);
                            SEL_DTMCS: sr <= DR_W'(dtmcs_c);
                            SEL_DMI: begin
                                sr <= {dr_addr, dr_data, cap_op_c};
                                if (busy_c) sticky <= 2'd3;
                            end
                            default:   sr <= '0;
                        endcase
                    end
                    // TDI enters at the top of the selected register's real length
                    SH_DR: begin
                        case (sel_c)
                            SEL_DMI: sr       <= {tdi, sr[DR_W-1:1]};
                            SEL_BYP: sr[0]    <= tdi;
                            default: sr[31:0] <= {tdi, sr[31:1]};
                        endcase
                    end
                    default: ;
                endcase
            end

            if (fall_c) begin
                tdo <= (tap == SH_DR) ? sr[0] : (tap == SH_IR) ? ir_sr[0] : 1'b0;
                if (tap == UPD_IR) ir <= ir_sr;
                if (tap == UPD_DR && sel_c == SEL_DTMCS) begin
                    if (sr[17]) begin
                        sticky  <= 2'd0;
                        launch  <= 1'b0;
                        discard <= dmi.req && !ack_c;
                    end else if (sr[16]) begin
                        sticky  <= 2'd0;
                    end
                end
                if (tap == UPD_DR && sel_c == SEL_DMI && sticky_a_c == 2'd0) begin
                    if (busy_c) begin
                        sticky <= 2'd3;
                    end else if (upd_op_c == 2'd1 || upd_op_c == 2'd2) begin
                        launch    <= 1'b1;
                        dmi.write <= (upd_op_c == 2'd2);
                        dmi.addr  <= sr[DR_W-1:34];
                        dmi.wdata <= sr[33:2];
                        dr_addr   <= sr[DR_W-1:34];
                        dr_data   <= sr[33:2];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dtm_dmi_hs.sv
// Directed bench for dtm_dmi_hs: JTAG bit-banging through the synchroniser plus a delayed-ack DM model.
module tb_dtm_dmi_hs;
    localparam int unsigned ABITS      = 7;
    localparam logic [31:0] IDCODE_VAL = 32'h0000_0001;
    localparam int          DMI_LEN    = 41;

    logic clk = 1'b0, rst_n = 1'b0;
    logic tck_ns = 1'b0, tms_ns = 1'b1, tdi_ns = 1'b0;
    logic tdo;

    int n_cmp = 0, n_bad = 0;
    bit          dm_en    = 1'b0;
    int          dm_delay = 5;
    logic [31:0] dm_rdata = '0;
    logic        dm_err   = 1'b0;
    int          dm_cnt   = 0;
    int          ack_cnt  = 0;

    dtm_dmi_hs_if #(.ABITS(ABITS)) dmi();

    dtm_dmi_hs #(
        .ABITS(ABITS), .IDCODE_VAL(IDCODE_VAL), .IDLE_HINT(3'd1), .IR_LEN(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tck_ns(tck_ns), .tms_ns(tms_ns), .tdi_ns(tdi_ns),
        .tdo(tdo), .dmi(dmi)
    );

    always #5 clk = ~clk;

    // DM model: single-cycle ack after dm_delay clks of dmi.req
    initial begin
        dmi.ack = 1'b0; dmi.rdata = '0; dmi.err = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dmi.ack) begin
                dmi.ack = 1'b0; dmi.err = 1'b0;
            end else if (dmi.req && dm_en) begin
                dm_cnt++;
                if (dm_cnt >= dm_delay) begin
                    dmi.ack = 1'b1; dmi.rdata = dm_rdata; dmi.err = dm_err;
                    dm_cnt = 0; ack_cnt++;
                end
            end else begin
                dm_cnt = 0;
            end
        end
    end

    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo_o);
        tms_ns = tms; tdi_ns = tdi;
        repeat (4) @(negedge clk);
        tdo_o  = tdo;
        tck_ns = 1'b1;
        repeat (4) @(negedge clk);
        tck_ns = 1'b0;
    endtask

    task automatic tap_reset();
        logic d;
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
    endtask

    task automatic shift_ir(input logic [4:0] ins, output logic [4:0] cap);
        logic d;
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        for (int i = 0; i < 5; i++) tck_cycle(i == 4, ins[i], cap[i]);
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
    endtask

    task automatic scan_dr(input logic [63:0] din, input int len, output logic [63:0] dout);
        logic d;
        dout = '0;
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        for (int i = 0; i < len; i++) tck_cycle(i == len - 1, din[i], dout[i]);
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (tdo !== 1'b0) begin n_bad++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
        n_cmp++; if (dmi.req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b expected 0", dmi.req); end
        n_cmp++; if (dmi.write !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %b expected 0", dmi.write); end
        n_cmp++; if (dmi.addr !== 7'h00) begin n_bad++; $display("FAIL reset_addr: got %h expected 00", dmi.addr); end
        n_cmp++; if (dmi.wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h expected 0", dmi.wdata); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_default_dr(input string name);
        logic [63:0] din, dout;
        logic [31:0] exp, din32;
        din32 = 32'hA5C3_0F96;
        din   = 64'(din32);
`ifdef DTM_IDCODE_EN
        exp = IDCODE_VAL;
`else
        exp = {din32[30:0], 1'b0};
`endif
        scan_dr(din, 32, dout);
        n_cmp++;
        if (dout[31:0] !== exp) begin n_bad++; $display("FAIL %s: got %h expected %h", name, dout[31:0], exp); end
    endtask

    task automatic test_dtmcs();
        logic [4:0]  cap;
        logic [63:0] dout;
        shift_ir(5'h10, cap);
        n_cmp++; if (cap !== 5'b00001) begin n_bad++; $display("FAIL ir_capture: got %b expected 00001", cap); end
        scan_dr(64'h0, 32, dout);
        n_cmp++; if (dout[31:0] !== 32'h0000_1071) begin n_bad++; $display("FAIL dtmcs: got %h expected 00001071", dout[31:0]); end
    endtask

    task automatic test_dmi_write();
        logic [4:0]  cap;
        logic [63:0] dout, exp;
        int cycles, hold_bad;
        dm_en = 1'b0;
        shift_ir(5'h11, cap);
        scan_dr(64'({7'h10, 32'hDEAD_BEEF, 2'd2}), DMI_LEN, dout);
        repeat (20) @(negedge clk);
        n_cmp++; if (dmi.req !== 1'b1) begin n_bad++; $display("FAIL wr_req: got %b expected 1", dmi.req); end
        n_cmp++; if (dmi.write !== 1'b1) begin n_bad++; $display("FAIL wr_write: got %b expected 1", dmi.write); end
        n_cmp++; if (dmi.addr !== 7'h10) begin n_bad++; $display("FAIL wr_addr: got %h expected 10", dmi.addr); end
        n_cmp++; if (dmi.wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_wdata: got %h expected deadbeef", dmi.wdata); end
        dm_delay = 5; dm_en = 1'b1;
        cycles = 0; hold_bad = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (dmi.req && (dmi.write !== 1'b1 || dmi.addr !== 7'h10 || dmi.wdata !== 32'hDEAD_BEEF)) hold_bad++;
        end while (dmi.req === 1'b1 && cycles < 50);
        n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL wr_hold: got %0d unstable clks expected 0", hold_bad); end
        n_cmp++; if (cycles !== 6) begin n_bad++; $display("FAIL wr_req_drop: got req low after %0d clks expected 6", cycles); end
        exp = 64'({7'h10, 32'hDEAD_BEEF, 2'd0});
        scan_dr(64'h0, DMI_LEN, dout);
        n_cmp++; if (dout[40:0] !== exp[40:0]) begin n_bad++; $display("FAIL wr_capture: got %h expected %h", dout[40:0], exp[40:0]); end
    endtask

    task automatic test_busy();
        logic [4:0]  cap;
        logic [63:0] dout, exp;
        int acks0;
        dm_delay = 200; dm_rdata = 32'h1234_5678; dm_err = 1'b0; dm_en = 1'b1;
        acks0 = ack_cnt;
        scan_dr(64'({7'h11, 32'h0, 2'd1}), DMI_LEN, dout);
        scan_dr(64'({7'h05, 32'h0, 2'd1}), DMI_LEN, dout);
        exp = 64'({7'h11, 32'h0, 2'd3});
        n_cmp++; if (dout[40:0] !== exp[40:0]) begin n_bad++; $display("FAIL busy_capture: got %h expected %h", dout[40:0], exp[40:0]); end
        repeat (10) @(negedge clk);
        n_cmp++; if (dmi.req !== 1'b0) begin n_bad++; $display("FAIL busy_no_req: got %b expected 0", dmi.req); end
        n_cmp++; if (ack_cnt - acks0 !== 1) begin n_bad++; $display("FAIL busy_acks: got %0d expected 1", ack_cnt - acks0); end
        shift_ir(5'h10, cap);
        scan_dr(64'h0001_0000, 32, dout);
        n_cmp++; if (dout[31:0] !== 32'h0000_1C71) begin n_bad++; $display("FAIL busy_dtmcs: got %h expected 00001c71", dout[31:0]); end
        shift_ir(5'h11, cap);
        scan_dr(64'h0, DMI_LEN, dout);
        exp = 64'({7'h11, 32'h1234_5678, 2'd0});
        n_cmp++; if (dout[40:0] !== exp[40:0]) begin n_bad++; $display("FAIL busy_result: got %h expected %h", dout[40:0], exp[40:0]); end
    endtask

    task automatic test_error();
        logic [4:0]  cap;
        logic [63:0] dout;
        int waited;
        dm_delay = 3; dm_rdata = 32'hCAFE_F00D; dm_err = 1'b1; dm_en = 1'b1;
        scan_dr(64'({7'h22, 32'h0, 2'd1}), DMI_LEN, dout);
        waited = 0;
        while (dmi.req === 1'b1 && waited < 100) begin @(negedge clk); waited++; end
        n_cmp++; if (dmi.req !== 1'b0) begin n_bad++; $display("FAIL err_ack_timeout: req %b expected 0", dmi.req); end
        dm_err = 1'b0; dm_en = 1'b0;
        scan_dr(64'({7'h23, 32'h0, 2'd1}), DMI_LEN, dout);
        n_cmp++; if (dout[1:0] !== 2'd2) begin n_bad++; $display("FAIL err_op: got %0d expected 2", dout[1:0]); end
        repeat (20) @(negedge clk);
        n_cmp++; if (dmi.req !== 1'b0) begin n_bad++; $display("FAIL err_blocked: got req %b expected 0", dmi.req); end
        shift_ir(5'h10, cap);
        scan_dr(64'h0002_0000, 32, dout);
        n_cmp++; if (dout[31:0] !== 32'h0000_1871) begin n_bad++; $display("FAIL err_dtmcs: got %h expected 00001871", dout[31:0]); end
        shift_ir(5'h11, cap);
        scan_dr(64'({7'h24, 32'h0, 2'd1}), DMI_LEN, dout);
        n_cmp++; if (dout[1:0] !== 2'd0) begin n_bad++; $display("FAIL hard_op: got %0d expected 0", dout[1:0]); end
        repeat (4) @(negedge clk);
        n_cmp++; if (dmi.req !== 1'b1) begin n_bad++; $display("FAIL hard_req: got %b expected 1", dmi.req); end
        n_cmp++; if (dmi.addr !== 7'h24 || dmi.write !== 1'b0) begin n_bad++; $display("FAIL hard_attr: got addr %h write %b expected 24 0", dmi.addr, dmi.write); end
        dm_en = 1'b1;
        waited = 0;
        while (dmi.req === 1'b1 && waited < 100) begin @(negedge clk); waited++; end
        n_cmp++; if (dmi.req !== 1'b0) begin n_bad++; $display("FAIL hard_ack_timeout: req %b expected 0", dmi.req); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] dout;
        logic d;
        dm_en = 1'b0;
        scan_dr(64'({7'h30, 32'h0BAD_F00D, 2'd2}), DMI_LEN, dout);
        repeat (4) @(negedge clk);
        n_cmp++; if (dmi.req !== 1'b1) begin n_bad++; $display("FAIL mid_req_before: got %b expected 1", dmi.req); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (dmi.req !== 1'b0) begin n_bad++; $display("FAIL mid_req_drop: got %b expected 0", dmi.req); end
        n_cmp++; if (tdo !== 1'b0) begin n_bad++; $display("FAIL mid_tdo: got %b expected 0", tdo); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tck_cycle(1'b0, 1'b0, d);
        test_default_dr("mid_ir_reset");
    endtask

    initial begin
        test_reset();
        tap_reset();
        test_default_dr("tlr_default_dr");
        test_dtmcs();
        test_dmi_write();
        test_busy();
        test_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
